// File: rtl/piarb_freeb_mgr_pkg.sv
// Shared definitions for the free-buffer manager: init FSM encoding, default
// parameter values and the round-robin index wrap helper.
package piarb_freeb_mgr_pkg;

  localparam int PIARB_BPTR_NBITS_DEF = 10;
  localparam int PIARB_NUM_CH_DEF     = 4;
  localparam int PIARB_LOW_WM_DEF     = 16;

  typedef enum logic [1:0] {
    INIT_IDLE   = 2'd0,
    RESET_FREEB = 2'd1,
    INIT_FREEB  = 2'd2,
    INIT_DONE   = 2'd3
  } init_state_t;

  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/piarb_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, the channel after the last
// winner holds top priority on the next cycle.
module piarb_rr_arb
  import piarb_freeb_mgr_pkg::*;
#(
  parameter int NUM_CH = PIARB_NUM_CH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IW-1:0] nxt_q;
  logic [IW-1:0] win;
  logic [IW-1:0] idx_b;
  logic          found;

  always_comb begin
    gnt   = '0;
    win   = nxt_q;
    idx_b = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_b = IW'(rr_wrap(int'(nxt_q) + i, NUM_CH));
      if (!found && req[idx_b]) begin
        found      = 1'b1;
        gnt[idx_b] = 1'b1;
        win        = idx_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_q <= '0;
    end else if (found) begin
      nxt_q <= IW'(rr_wrap(int'(win) + 1, NUM_CH));
    end
  end

endmodule

// File: rtl/piarb_freeb_mgr.sv
// Free-buffer pointer pool with round-robin allocation and 2-entry prefetch.
// Optional in-use bitmap for double-free detection: PIARB_FREEB_DBL_FREE_CHK_EN.
module piarb_freeb_mgr
  import piarb_freeb_mgr_pkg::*;
#(
  parameter int BPTR_NBITS = PIARB_BPTR_NBITS_DEF,
  parameter int NUM_CH     = PIARB_NUM_CH_DEF,
  parameter int LOW_WM     = PIARB_LOW_WM_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeb_init,
  output logic                  freeb_init_done,
  input  logic                  rel_buf_valid,
  input  logic [BPTR_NBITS-1:0] rel_buf_ptr,
  input  logic [NUM_CH-1:0]     alloc_req,
  output logic [NUM_CH-1:0]     alloc_gnt,
  output logic [BPTR_NBITS-1:0] alloc_ptr,
  output logic [BPTR_NBITS:0]   free_count,
  output logic                  free_low,
  output logic                  rel_ovf_err,
  output logic                  dbl_free_err
);

  localparam int DEPTH = 1 << BPTR_NBITS;
  localparam logic [BPTR_NBITS:0] DEPTH_C  = (BPTR_NBITS+1)'(DEPTH);
  localparam logic [BPTR_NBITS:0] LOW_WM_C = (BPTR_NBITS+1)'(LOW_WM);

  init_state_t state_q, state_d;
  logic [BPTR_NBITS-1:0] init_ptr;
  logic                  pool_live, active;

  logic [BPTR_NBITS-1:0] mem [DEPTH];
  logic [BPTR_NBITS-1:0] wr_addr, rd_addr, wr_data;
  logic [BPTR_NBITS:0]   fifo_cnt;
  logic                  wr_en, rd_en;
  logic                  rd_vld_p1;
  logic [BPTR_NBITS-1:0] rd_data_p1;

  logic [BPTR_NBITS-1:0] pf0_p2, pf1_p2;
  logic [1:0]            pf_cnt, pf_occ;

  logic [NUM_CH-1:0]     arb_req, arb_gnt;
  logic                  gnt_fire;
  logic                  rel_ovf, rel_dbl, rel_acc;
  logic [BPTR_NBITS:0]   fc_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_IDLE:   state_d = RESET_FREEB;
      RESET_FREEB: state_d = INIT_FREEB;
      INIT_FREEB:  if (&init_ptr) state_d = INIT_DONE;
      INIT_DONE:   if (freeb_init) state_d = INIT_IDLE;
      default:     state_d = INIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || state_q != INIT_FREEB) init_ptr <= '0;
    else                              init_ptr <= init_ptr + 1'b1;
  end

  assign freeb_init_done = (state_q == INIT_DONE);
  assign pool_live       = (state_q == INIT_FREEB) || (state_q == INIT_DONE);
  assign active          = (state_q == INIT_DONE) && !freeb_init;

  // Release qualification: overflow takes precedence over double-free
  assign rel_ovf = active && rel_buf_valid && (free_count == DEPTH_C);

`ifdef PIARB_FREEB_DBL_FREE_CHK_EN
  logic [DEPTH-1:0] in_use;

  assign rel_dbl = active && rel_buf_valid && !rel_ovf && !in_use[rel_buf_ptr];

  always_ff @(posedge clk) begin
    if (rst || !pool_live) begin
      in_use <= '0;
    end else begin
      if (gnt_fire) in_use[pf0_p2]      <= 1'b1;
      if (rel_acc)  in_use[rel_buf_ptr] <= 1'b0;
    end
  end
`else
  assign rel_dbl = 1'b0;
`endif

  assign rel_acc = active && rel_buf_valid && !rel_ovf && !rel_dbl;

  assign arb_req  = (active && pf_cnt != 2'd0) ? alloc_req : '0;
  assign gnt_fire = |arb_gnt;

  piarb_rr_arb #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .gnt (arb_gnt)
  );

  // Stage p0 -> p1: pool FIFO write and registered RAM read
  assign wr_en   = (state_q == INIT_FREEB) || rel_acc;
  assign wr_data = (state_q == INIT_FREEB) ? init_ptr : rel_buf_ptr;
  assign pf_occ  = pf_cnt + {1'b0, rd_vld_p1} - {1'b0, gnt_fire};
  assign rd_en   = pool_live && (fifo_cnt != '0) && (pf_occ < 2'd2);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_p1 <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst || !pool_live) begin
      wr_addr   <= '0;
      rd_addr   <= '0;
      fifo_cnt  <= '0;
      rd_vld_p1 <= 1'b0;
      pf_cnt    <= 2'd0;
    end else begin
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      if (rd_en) rd_addr <= rd_addr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      rd_vld_p1 <= rd_en;
      case ({gnt_fire, rd_vld_p1})
        2'b10:   pf_cnt <= pf_cnt - 1'b1;
        2'b01:   pf_cnt <= pf_cnt + 1'b1;
        default: pf_cnt <= pf_cnt;
      endcase
    end
  end

  // Stage p1 -> p2: prefetch queue, pf0_p2 is the next pointer to grant
  always_ff @(posedge clk) begin
    case ({gnt_fire, rd_vld_p1})
      2'b11: begin
        if (pf_cnt == 2'd2) begin
          pf0_p2 <= pf1_p2;
          pf1_p2 <= rd_data_p1;
        end else begin
          pf0_p2 <= rd_data_p1;
        end
      end
      2'b10: pf0_p2 <= pf1_p2;
      2'b01: begin
        if (pf_cnt == 2'd0) pf0_p2 <= rd_data_p1;
        else                pf1_p2 <= rd_data_p1;
      end
      default: ;
    endcase
  end

  always_comb begin
    fc_d = free_count;
    if (!pool_live)                    fc_d = '0;
    else if (state_q == INIT_FREEB)    fc_d = free_count + 1'b1;
    else if (rel_acc && !gnt_fire)     fc_d = free_count + 1'b1;
    else if (!rel_acc && gnt_fire)     fc_d = free_count - 1'b1;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_gnt    <= '0;
      alloc_ptr    <= '0;
      free_count   <= '0;
      free_low     <= 1'b0;
      rel_ovf_err  <= 1'b0;
      dbl_free_err <= 1'b0;
    end else begin
      alloc_gnt    <= arb_gnt;
      if (gnt_fire) alloc_ptr <= pf0_p2;
      free_count   <= fc_d;
      free_low     <= (fc_d < LOW_WM_C);
      rel_ovf_err  <= rel_ovf;
      dbl_free_err <= rel_dbl;
    end
  end

endmodule

// File: tb/tb_piarb_freeb_mgr.sv
// Scoreboard bench for piarb_freeb_mgr (BPTR_NBITS=4, NUM_CH=4, LOW_WM=4).
module tb_piarb_freeb_mgr;

  localparam int BW    = 4;
  localparam int NCH   = 4;
  localparam int LWM   = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          freeb_init;
  logic          freeb_init_done;
  logic          rel_buf_valid;
  logic [BW-1:0] rel_buf_ptr;
  logic [NCH-1:0] alloc_req;
  logic [NCH-1:0] alloc_gnt;
  logic [BW-1:0] alloc_ptr;
  logic [BW:0]   free_count;
  logic          free_low;
  logic          rel_ovf_err;
  logic          dbl_free_err;

  piarb_freeb_mgr #(
    .BPTR_NBITS(BW),
    .NUM_CH    (NCH),
    .LOW_WM    (LWM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeb_init     (freeb_init),
    .freeb_init_done(freeb_init_done),
    .rel_buf_valid  (rel_buf_valid),
    .rel_buf_ptr    (rel_buf_ptr),
    .alloc_req      (alloc_req),
    .alloc_gnt      (alloc_gnt),
    .alloc_ptr      (alloc_ptr),
    .free_count     (free_count),
    .free_low       (free_low),
    .rel_ovf_err    (rel_ovf_err),
    .dbl_free_err   (dbl_free_err)
  );

  typedef struct {
    int           cyc;
    logic [3:0]   gnt;
    logic [3:0]   ptr;
  } exp_t;

  exp_t      sb[$];
  int        m_pool[$];
  int        m_fc;
  int        m_nxt;
  bit [15:0] m_inuse;
  int        cyc;
  int        n_checks;
  int        n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Grant monitor: pops the scoreboard whenever a grant appears or is due
  always @(negedge clk) begin
    if (!rst) begin
      if (alloc_gnt != '0) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_gnt", 32'(alloc_gnt), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("gnt_cycle", cyc, e.cyc);
          check_eq("gnt_ch", 32'(alloc_gnt), 32'(e.gnt));
          check_eq("gnt_ptr", 32'(alloc_ptr), 32'(e.ptr));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("missing_gnt", 32'(alloc_gnt), 32'(e.gnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] r);
    for (int i = 0; i < NCH; i++) begin
      int idx;
      idx = (m_nxt + i) % NCH;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // One cycle of stimulus; model predicts grant, release acceptance and flags
  task automatic drive(input logic [3:0] r, input bit rv, input int p);
    bit   g, acc, ovf, dbl;
    int   w, gp;
    exp_t e;
    g = 0; dbl = 0;
    alloc_req     = r;
    rel_buf_valid = rv;
    rel_buf_ptr   = 4'(p);
    ovf = rv && (m_fc == DEPTH);
`ifdef PIARB_FREEB_DBL_FREE_CHK_EN
    if (rv && !ovf && !m_inuse[p]) dbl = 1;
`endif
    acc = rv && !ovf && !dbl;
    if (r != 4'b0 && m_pool.size() > 0) begin
      w  = rr_pick(r);
      gp = m_pool.pop_front();
      e.cyc = cyc + 1;
      e.gnt = 4'(1 << w);
      e.ptr = 4'(gp);
      sb.push_back(e);
      m_nxt = (w + 1) % NCH;
      g = 1;
    end
    if (acc) begin
      m_inuse[p] = 1'b0;
      m_pool.push_back(p);
    end
    if (g) m_inuse[gp] = 1'b1;
    m_fc = m_fc + int'(acc) - int'(g);
    tick();
    alloc_req     = '0;
    rel_buf_valid = 1'b0;
    check_eq("rel_ovf_err", 32'(rel_ovf_err), 32'(ovf));
    check_eq("dbl_free_err", 32'(dbl_free_err), 32'(dbl));
    check_eq("free_count", 32'(free_count), 32'(m_fc));
    check_eq("free_low", 32'(free_low), 32'(m_fc < LWM));
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!freeb_init_done && n < 200) begin
      tick();
      n++;
    end
    check_eq("init_done", 32'(freeb_init_done), 32'h1);
    check_eq("init_cycles_ge16", 32'(n >= DEPTH), 32'h1);
    check_eq("init_free_count", 32'(free_count), 32'(DEPTH));
    check_eq("init_free_low", 32'(free_low), 32'h0);
    m_pool.delete();
    for (int i = 0; i < DEPTH; i++) m_pool.push_back(i);
    m_fc    = DEPTH;
    m_inuse = '0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    m_nxt    = 0;
    m_fc     = 0;
    m_inuse  = '0;
    rst = 1'b1; freeb_init = 1'b0; alloc_req = '0;
    rel_buf_valid = 1'b0; rel_buf_ptr = '0;
    repeat (3) tick();

    check_eq("rst_gnt", 32'(alloc_gnt), 32'h0);
    check_eq("rst_ptr", 32'(alloc_ptr), 32'h0);
    check_eq("rst_done", 32'(freeb_init_done), 32'h0);
    check_eq("rst_free_count", 32'(free_count), 32'h0);
    check_eq("rst_free_low", 32'(free_low), 32'h0);
    check_eq("rst_ovf", 32'(rel_ovf_err), 32'h0);
    check_eq("rst_dbl", 32'(dbl_free_err), 32'h0);

    rst = 1'b0;
    wait_init();

    // overflow: release into a full pool
    drive(4'b0, 1, 3);
    drive(4'b0, 0, 0);

    // round-robin sweep then drain the rest with mixed request patterns
    repeat (4) drive(4'b1111, 0, 0);
    for (int k = 4; k < DEPTH; k++) drive(4'($urandom_range(1, 15)), 0, 0);
    drive(4'b0, 0, 0);

    // exhaustion, then a released pointer becomes allocatable again
    drive(4'b0010, 0, 0);
    drive(4'b0, 0, 0);
    drive(4'b0, 1, 5);
    repeat (3) drive(4'b0, 0, 0);
    drive(4'b0100, 0, 0);
    drive(4'b0, 0, 0);

    // simultaneous grant and release
    drive(4'b0, 1, 7);
    drive(4'b0, 1, 9);
    repeat (3) drive(4'b0, 0, 0);
    drive(4'b1000, 1, 11);
    drive(4'b0, 0, 0);

    // release of an in-use pointer, then again (double free when checked)
    drive(4'b0, 1, 0);
`ifdef PIARB_FREEB_DBL_FREE_CHK_EN
    drive(4'b0, 1, 0);
`endif
    drive(4'b0, 0, 0);

    // re-init after traffic
    freeb_init = 1'b1;
    tick();
    freeb_init = 1'b0;
    check_eq("reinit_done_drop", 32'(freeb_init_done), 32'h0);
    wait_init();
    repeat (4) drive(4'b1111, 0, 0);
    drive(4'b0101, 0, 0);
    drive(4'b0, 0, 0);

    // reset in the middle of traffic discards the in-flight request
    alloc_req = 4'b1111; rel_buf_valid = 1'b1; rel_buf_ptr = 4'd2; rst = 1'b1;
    tick();
    alloc_req = '0; rel_buf_valid = 1'b0;
    check_eq("midrst_gnt", 32'(alloc_gnt), 32'h0);
    check_eq("midrst_free_count", 32'(free_count), 32'h0);
    check_eq("midrst_done", 32'(freeb_init_done), 32'h0);
    check_eq("midrst_ovf", 32'(rel_ovf_err), 32'h0);
    tick();
    rst   = 1'b0;
    m_nxt = 0;
    wait_init();
    repeat (4) drive(4'b1111, 0, 0);
    drive(4'b0, 0, 0);
    drive(4'b0, 0, 0);

    check_eq("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/piarb_freeb_mgr.md
PIARB_FREEB_MGR -- requirements
Module: piarb_freeb_mgr

Interface
REQ-001 SHALL have parameter BPTR_NBITS, default 10: buffer pointer width; pool depth DEPTH = 2**BPTR_NBITS.
REQ-002 SHALL have parameter NUM_CH, default 4: number of independent allocation request channels.
REQ-003 SHALL have parameter LOW_WM, default 16: free-count low-water threshold.
REQ-004 SHALL have one clock and a synchronous active-high reset, with ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have ports: freeb_init in 1, re-initialise pool; freeb_init_done out 1, pool ready.
REQ-006 SHALL have ports: rel_buf_valid in 1; rel_buf_ptr in BPTR_NBITS, pointer returned to pool.
REQ-007 SHALL have ports: alloc_req in NUM_CH, per-channel single-cycle request; alloc_gnt out NUM_CH, one-hot grant; alloc_ptr out BPTR_NBITS, granted pointer.
REQ-008 SHALL have ports: free_count out BPTR_NBITS+1; free_low out 1; rel_ovf_err out 1; dbl_free_err out 1.

Function
REQ-009 SHALL run init FSM INIT_IDLE->RESET_FREEB->INIT_FREEB->INIT_DONE, advancing one state per cycle except INIT_FREEB.
REQ-010 SHALL, in INIT_FREEB, write pointers 0..DEPTH-1 into the pool FIFO, one per cycle, in ascending order, then enter INIT_DONE.
REQ-011 SHALL assert freeb_init_done only in INIT_DONE; freeb_init in INIT_DONE returns the FSM to INIT_IDLE and flushes all pointers.
REQ-012 SHALL ignore alloc_req and rel_buf_valid while freeb_init_done is low.
REQ-013 SHALL keep a 2-entry prefetch stage fed from the pool FIFO so that a grant never waits on RAM read latency.
REQ-014 SHALL arbitrate alloc_req round-robin: the last granted channel gets lowest priority next; at most one grant per cycle.
REQ-015 SHALL assert alloc_gnt and alloc_ptr one cycle after the winning alloc_req when a prefetch entry is available; otherwise no grant, and the request is dropped (requester re-requests).
REQ-016 SHALL accept a release in the cycle it is presented; the pointer becomes allocatable no earlier than 3 cycles later.
REQ-017 SHALL support a grant and a release in the same cycle; free_count is then unchanged.
REQ-018 SHALL make free_count equal to pointers held in FIFO plus prefetch, registered, updated the cycle after each grant/release; equals DEPTH after init.
REQ-019 SHALL assert free_low when free_count < LOW_WM.
REQ-020 SHALL drop a release when free_count == DEPTH and pulse rel_ovf_err for one cycle.

Reset
REQ-021 SHALL on rst: FSM to INIT_IDLE, FIFO and prefetch empty, round-robin pointer to channel 0, all outputs 0; after rst release, init restarts automatically.
REQ-022 SHALL treat rst asserted mid-init or mid-traffic identically: all in-flight grants discarded, no partial outputs.

Configuration
REQ-023 SHALL compile a DEPTH-bit in-use bitmap when PIARB_FREEB_DBL_FREE_CHK_EN is defined: bit set on grant, cleared on release; releasing a clear bit drops the release and pulses dbl_free_err one cycle.
REQ-024 SHALL, without PIARB_FREEB_DBL_FREE_CHK_EN, have no bitmap, accept all releases (subject to REQ-020), and tie dbl_free_err to 0.

Structure
REQ-025 SHALL place init FSM state encodings and the default parameter values in the shared piarb package.
REQ-026 SHALL instantiate the round-robin arbiter as sub-module piarb_rr_arb (NUM_CH-wide); pool storage uses the existing single-clock RAM FIFO.

Verification
REQ-027 SHALL verify init: rst, BPTR_NBITS=4 -> freeb_init_done after 16+ cycles, free_count=16, first 16 grants return 0..15 in order.
REQ-028 SHALL verify arbitration: alloc_req=4'b1111 held 4 cycles -> grants ch0,ch1,ch2,ch3, each one cycle after request.
REQ-029 SHALL verify exhaustion: 16 grants then request -> no grant, free_count=0, free_low=1; release ptr 5 -> ptr 5 granted on the next request issued 3+ cycles later.
REQ-030 SHALL verify overflow: release ptr 3 at free_count=16 -> rel_ovf_err pulse, free_count stays 16.
REQ-031 SHALL verify double free with PIARB_FREEB_DBL_FREE_CHK_EN: grant ptr 0, release 0 twice -> second release pulses dbl_free_err, free_count increases by 1 only.
REQ-032 SHALL verify re-init: freeb_init after traffic -> freeb_init_done drops, then free_count=16 and ascending order restored.
